// File: rtl/vga_frame_fetch.sv
// Avalon-MM read master that streams one frame from the SDRAM frame buffer
// into a credit-controlled pixel FIFO feeding the VGA display stage.
module vga_frame_fetch #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] frame_buffer_ptr,
  input  logic        frame_start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        underflow
);

  localparam int unsigned N  = H_RES * V_RES;
  localparam int unsigned NW = $clog2(N + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_ABORT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [NW-1:0] issued_q, issued_d;
  logic [CW-1:0] pending_q, pending_d;
  logic          sof_arm_q, sof_arm_d;
  logic          stall_q;

  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] mcount_q, mcount_d;
  logic          out_valid_q, out_valid_d;
  logic [24:0]   out_q, out_d;
  logic          mem_we;

  logic          accept, last_accept, flush, wr_en, pop, out_free, restart;
  logic          credit_ok;
  logic [CW:0]   credit_used;
  logic [24:0]   wdata;
  logic          unused_hi;

  assign unused_hi = ^avm_readdata[31:24];

  // Output register counts as a FIFO slot so outstanding reads always have room.
  assign credit_used = {1'b0, pending_q} + {1'b0, mcount_q} + (CW+1)'(out_valid_q);
  assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    case (state_q)
      S_FETCH: avm_read = credit_ok | stall_q;
      S_ABORT: avm_read = stall_q;
      default: avm_read = 1'b0;
    endcase
  end

  assign avm_address = addr_q;
  assign accept      = avm_read & ~avm_waitrequest;
  assign last_accept = accept && (state_q == S_FETCH) && (issued_q == NW'(N - 1));
  assign flush       = (state_q == S_ABORT) ||
                       (frame_start && (state_q == S_FETCH || state_q == S_DRAIN));
  assign wr_en       = avm_readdatavalid & ~flush;
  assign wdata       = {sof_arm_q, avm_readdata[23:0]};
  assign pop         = out_valid_q & pix_ready;
  assign out_free    = ~out_valid_q | pop;

  always_comb begin
    pending_d = pending_q;
    if (accept && !avm_readdatavalid)
      pending_d = pending_q + CW'(1);
    else if (!accept && avm_readdatavalid)
      pending_d = pending_q - CW'(1);
  end

  // Show-ahead FIFO: an empty output stage takes incoming data directly.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    mcount_d    = mcount_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    mem_we      = 1'b0;
    if (flush) begin
      wptr_d      = '0;
      rptr_d      = '0;
      mcount_d    = '0;
      out_valid_d = 1'b0;
    end else if (out_free) begin
      if (mcount_q != '0) begin
        out_d       = mem_q[rptr_q];
        out_valid_d = 1'b1;
        rptr_d      = rptr_q + AW'(1);
        if (wr_en) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + AW'(1);
        end else begin
          mcount_d = mcount_q - CW'(1);
        end
      end else if (wr_en) begin
        out_d       = wdata;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (wr_en) begin
      mem_we   = 1'b1;
      wptr_d   = wptr_q + AW'(1);
      mcount_d = mcount_q + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_FETCH;
          restart = 1'b1;
        end
      end
      S_FETCH: begin
        if (frame_start)      state_d = S_ABORT;
        else if (last_accept) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (frame_start)
          state_d = S_ABORT;
        else if (pending_d == '0 && mcount_d == '0 && !out_valid_d)
          state_d = S_IDLE;
      end
      S_ABORT: begin
        if (!frame_start && pending_q == '0 && !avm_read) begin
          state_d = S_FETCH;
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    issued_d  = issued_q;
    sof_arm_d = sof_arm_q;
    if (wr_en) sof_arm_d = 1'b0;
    if (restart) begin
      addr_d    = frame_buffer_ptr;
      issued_d  = '0;
      sof_arm_d = 1'b1;
    end else if (accept) begin
      addr_d   = addr_q + 32'd4;
      issued_d = issued_q + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issued_q    <= '0;
      pending_q   <= '0;
      sof_arm_q   <= 1'b0;
      stall_q     <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      mcount_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issued_q    <= issued_d;
      pending_q   <= pending_d;
      sof_arm_q   <= sof_arm_d;
      stall_q     <= avm_read & avm_waitrequest;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mcount_q    <= mcount_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q] <= wdata;
  end

  assign pix_valid = out_valid_q;
  assign pix_data  = out_q[23:0];
  assign pix_sof   = out_valid_q & out_q[24];
  assign underflow = pix_ready & ~out_valid_q &
                     ((state_q == S_FETCH) || (state_q == S_DRAIN));

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Scoreboard bench for vga_frame_fetch on a 4x2 frame with a 4-entry FIFO,
// driven against a behavioural Avalon slave returning readdata = address.
module tb_vga_frame_fetch;

  localparam int unsigned NPIX = 8;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] frame_buffer_ptr;
  logic        frame_start;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        underflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0, nacc = 0, nret = 0, uf_cnt = 0;
  int unsigned lat = 1, wr_mode = 0, acc_limit = 0;

  logic [24:0] exp_pix_q[$];
  logic [31:0] exp_addr_q[$];
  rsp_t        rsp_q[$];

  vga_frame_fetch #(.H_RES(4), .V_RES(2), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .frame_buffer_ptr  (frame_buffer_ptr),
    .frame_start       (frame_start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_sof           (pix_sof),
    .underflow         (underflow)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: acts 1 time unit after the falling edge, after stimulus has settled.
  initial begin : slave
    logic        stall_prev;
    logic [31:0] stall_addr;
    rsp_t        r;
    stall_prev        = 1'b0;
    stall_addr        = '0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (reset) begin
        rsp_q.delete();
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        stall_prev        = 1'b0;
      end else begin
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
          r = rsp_q.pop_front();
          avm_readdata      = r.addr;
          avm_readdatavalid = 1'b1;
          nret++;
        end else begin
          avm_readdatavalid = 1'b0;
          avm_readdata      = 32'hDEAD_BEEF;
        end
        case (wr_mode)
          1:       avm_waitrequest = ($urandom_range(0, 1) == 1);
          2:       avm_waitrequest = (nacc >= acc_limit);
          default: avm_waitrequest = 1'b0;
        endcase
        #1;
        if (stall_prev) begin
          check("stall_read_held", {31'b0, avm_read}, 32'd1);
          check("stall_addr_held", avm_address, stall_addr);
        end
        if (avm_read && !avm_waitrequest) begin
          if (exp_addr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL read_extra: got address 0x%0h, expected no read", avm_address);
          end else begin
            check("read_addr", avm_address, exp_addr_q.pop_front());
          end
          r.addr = avm_address;
          r.due  = cyc + lat;
          rsp_q.push_back(r);
          nacc++;
        end
        stall_prev = avm_read && avm_waitrequest;
        stall_addr = avm_address;
      end
    end
  end

  initial begin : monitor
    logic [24:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && pix_valid && pix_ready) begin
        if (exp_pix_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pix_extra: got 0x%0h, expected no pixel", pix_data);
        end else begin
          e = exp_pix_q.pop_front();
          check("pix_data", {8'h0, pix_data}, {8'h0, e[23:0]});
          check("pix_sof", {31'b0, pix_sof}, {31'b0, e[24]});
        end
      end
      if (underflow) uf_cnt++;
    end
  end

  task automatic expect_frame(input logic [31:0] ptr, input bit with_pixels);
    logic [31:0] a;
    for (int unsigned i = 0; i < NPIX; i++) begin
      a = ptr + 32'(4 * i);
      exp_addr_q.push_back(a);
      if (with_pixels) exp_pix_q.push_back({(i == 0), a[23:0]});
    end
  endtask

  task automatic start_frame(input logic [31:0] ptr);
    frame_buffer_ptr = ptr;
    frame_start      = 1'b1;
    @(negedge clk);
    frame_start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while ((exp_pix_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, 32'(exp_pix_q.size() + exp_addr_q.size()), 32'd0);
    exp_pix_q.delete();
    exp_addr_q.delete();
    repeat (3) @(negedge clk);
    check({name, "_idle_read"}, {31'b0, avm_read}, 32'd0);
    check({name, "_idle_valid"}, {31'b0, pix_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_avm_read"}, {31'b0, avm_read}, 32'd0);
    check({name, "_avm_address"}, avm_address, 32'd0);
    check({name, "_pix_valid"}, {31'b0, pix_valid}, 32'd0);
    check({name, "_pix_sof"}, {31'b0, pix_sof}, 32'd0);
    check({name, "_pix_data"}, {8'h0, pix_data}, 32'd0);
    check({name, "_underflow"}, {31'b0, underflow}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int unsigned n;
    reset            = 1'b1;
    frame_start      = 1'b0;
    frame_buffer_ptr = '0;
    pix_ready        = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Small frame, 1-cycle slave, always ready: underflow only before pixel 0.
    lat = 1; wr_mode = 0; pix_ready = 1'b1; uf_cnt = 0;
    expect_frame(32'h1000, 1'b1);
    start_frame(32'h1000);
    wait_done("t1", 100);
    check("t1_underflow_cnt", uf_cnt, 32'd2);

    // Random waitrequest.
    lat = 2; wr_mode = 1;
    expect_frame(32'h1000, 1'b1);
    start_frame(32'h1000);
    wait_done("t2", 400);
    wr_mode = 0;

    // Credit limit with the display stage stalled.
    lat = 1; pix_ready = 1'b0; nacc = 0;
    expect_frame(32'h5000, 1'b1);
    start_frame(32'h5000);
    repeat (30) @(negedge clk);
    check("t3_reads_full", nacc, 32'd4);
    check("t3_read_low_full", {31'b0, avm_read}, 32'd0);
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_reads_after_pop", nacc, 32'd5);
    check("t3_read_low_again", {31'b0, avm_read}, 32'd0);
    pix_ready = 1'b1;
    wait_done("t3", 100);

    // Restart mid-frame: 3 reads accepted, 4th stalled, 1 word returned.
    lat = 3; wr_mode = 2; acc_limit = 3; nacc = 0; nret = 0; pix_ready = 1'b0;
    exp_addr_q.push_back(32'h1000);
    exp_addr_q.push_back(32'h1004);
    exp_addr_q.push_back(32'h1008);
    exp_addr_q.push_back(32'h100C);
    expect_frame(32'h2000, 1'b1);
    start_frame(32'h1000);
    n = 0;
    while (nret == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_first_return", nret, 32'd1);
    check("t4_reads_before_abort", nacc, 32'd3);
    start_frame(32'h2000);
    repeat (5) @(negedge clk);
    wr_mode = 0; pix_ready = 1'b1;
    wait_done("t4", 200);

    // Long slave latency: underflow every empty cycle while fetching/draining.
    lat = 20; wr_mode = 0; pix_ready = 1'b1; uf_cnt = 0;
    expect_frame(32'h6000, 1'b1);
    start_frame(32'h6000);
    wait_done("t5", 300);
    check("t5_underflow_cnt", uf_cnt, 32'd39);

    // Reset in the middle of a fetch, then a clean frame.
    lat = 1; pix_ready = 1'b0; nacc = 0;
    expect_frame(32'h7000, 1'b0);
    start_frame(32'h7000);
    n = 0;
    while (nacc < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reads_before_reset", {31'b0, (nacc >= 3)}, 32'd1);
    reset = 1'b1;
    exp_addr_q.delete();
    @(negedge clk);
    reset = 1'b0;
    pix_ready = 1'b1;
    #2;
    check_reset_outputs("t6_midreset");
    @(negedge clk);
    expect_frame(32'h3000, 1'b1);
    start_frame(32'h3000);
    wait_done("t6", 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
